// File: rtl/cluster_pkg.sv
// Shared constants and helpers for the cluster rate monitor.
// WINDOW defaults to one LHC orbit measured in clock4x cycles.
package cluster_pkg;

    localparam int CNT_W_DEF    = 11;
    localparam int BX_PER_ORBIT = 3564;
    localparam int CLK4X_PER_BX = 4;
    localparam int WINDOW_DEF   = BX_PER_ORBIT * CLK4X_PER_BX;

    // Unsigned add clamped to (2^w - 1). The addition is carried out one
    // bit wider than the operands so a wrap can never hide an overflow.
    // Callers keep w below 64 and truncate the result to their own width.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] full;
        logic [64:0] lim;
        full = {1'b0, a} + {1'b0, b};
        lim  = (65'd1 << w) - 65'd1;
        if (full > lim) begin
            return lim[63:0];
        end else begin
            return full[63:0];
        end
    endfunction

endpackage

// File: rtl/cluster_rate_monitor_overflow_stretcher.sv
// Retriggerable pulse stretcher: each overflow reloads a down-counter and
// the registered flag stays high while that counter is non-zero.
module overflow_stretcher #(
    parameter int STRETCH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ovf_i,
    output logic stretch_o
);

    localparam int                SCNT_W    = $clog2(STRETCH + 1);
    localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(STRETCH);
    localparam logic [SCNT_W-1:0] SCNT_ZERO = {SCNT_W{1'b0}};

    logic [SCNT_W-1:0] scnt_q;
    logic [SCNT_W-1:0] scnt_d;
    logic              flag_q;
    logic              flag_d;

    // Reload on overflow, otherwise count down and stop at zero.
    always_comb begin
        scnt_d = scnt_q;
        flag_d = (scnt_q != SCNT_ZERO);
        if (ovf_i) begin
            scnt_d = SCNT_LOAD;
        end else if (scnt_q != SCNT_ZERO) begin
            scnt_d = scnt_q - SCNT_W'(1);
        end else begin
            scnt_d = SCNT_ZERO;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q <= SCNT_ZERO;
            flag_q <= 1'b0;
        end else begin
            scnt_q <= scnt_d;
            flag_q <= flag_d;
        end
    end

    assign stretch_o = flag_q;

endmodule

// File: rtl/cluster_rate_monitor.sv
// Windowed statistics on the cluster counter output: peak, saturating sum
// and overflow-cycle count per WINDOW accepted samples, plus a stretched
// overflow flag.
module cluster_rate_monitor
    import cluster_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int WINDOW  = WINDOW_DEF,
    parameter int SUM_W   = 32,
    parameter int OVF_W   = 16,
    parameter int STRETCH = 8
) (
    input  logic             clock4x,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             overflow_i,
    input  logic             enable_i,
    input  logic             resync_i,
    output logic [CNT_W-1:0] peak_o,
    output logic [SUM_W-1:0] sum_o,
    output logic [OVF_W-1:0] ovf_cycles_o,
    output logic             report_o,
    output logic             ovf_stretch_o
);

    localparam int                WCNT_W    = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);

    // Input stage.
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic              en_q;
    logic              resync_q;

    // Window accumulators. On a window close they hold the final totals
    // for one cycle (close_q high) so the report stage can copy them; the
    // next sample then builds on a zero base, so no gap cycle is needed.
    logic [CNT_W-1:0]  peak_acc_q, peak_acc_d, peak_base;
    logic [SUM_W-1:0]  sum_acc_q,  sum_acc_d,  sum_base;
    logic [OVF_W-1:0]  ovf_acc_q,  ovf_acc_d,  ovf_base;
    logic [WCNT_W-1:0] wcnt_q,     wcnt_d,     wcnt_base;
    logic              close_q,    close_d;

    // Report stage.
    logic [CNT_W-1:0]  peak_o_q, peak_o_d;
    logic [SUM_W-1:0]  sum_o_q,  sum_o_d;
    logic [OVF_W-1:0]  ovf_o_q,  ovf_o_d;
    logic              report_q, report_d;

    // Register the raw inputs once; everything downstream uses these copies.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
            en_q     <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_i;
            ovf_q    <= overflow_i;
            en_q     <= enable_i;
            resync_q <= resync_i;
        end
    end

    // Accumulate accepted samples; resync discards the sample and the window.
    always_comb begin
        peak_base = close_q ? {CNT_W{1'b0}}  : peak_acc_q;
        sum_base  = close_q ? {SUM_W{1'b0}}  : sum_acc_q;
        ovf_base  = close_q ? {OVF_W{1'b0}}  : ovf_acc_q;
        wcnt_base = close_q ? {WCNT_W{1'b0}} : wcnt_q;

        peak_acc_d = peak_base;
        sum_acc_d  = sum_base;
        ovf_acc_d  = ovf_base;
        wcnt_d     = wcnt_base;
        close_d    = 1'b0;

        if (resync_q) begin
            peak_acc_d = {CNT_W{1'b0}};
            sum_acc_d  = {SUM_W{1'b0}};
            ovf_acc_d  = {OVF_W{1'b0}};
            wcnt_d     = {WCNT_W{1'b0}};
        end else if (en_q) begin
            peak_acc_d = (cnt_q > peak_base) ? cnt_q : peak_base;
            sum_acc_d  = SUM_W'(sat_add(64'(sum_base), 64'(cnt_q), SUM_W));
            ovf_acc_d  = OVF_W'(sat_add(64'(ovf_base), 64'(ovf_q), OVF_W));
            if (wcnt_base == WCNT_LAST) begin
                close_d = 1'b1;
                wcnt_d  = {WCNT_W{1'b0}};
            end else begin
                wcnt_d  = wcnt_base + WCNT_W'(1);
            end
        end else begin
            close_d = 1'b0;
        end
    end

    // Publish the finished window one cycle after it closes.
    always_comb begin
        peak_o_d = peak_o_q;
        sum_o_d  = sum_o_q;
        ovf_o_d  = ovf_o_q;
        report_d = close_q;
        if (close_q) begin
            peak_o_d = peak_acc_q;
            sum_o_d  = sum_acc_q;
            ovf_o_d  = ovf_acc_q;
        end else begin
            report_d = 1'b0;
        end
    end

    // Accumulator and report registers.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            peak_acc_q <= {CNT_W{1'b0}};
            sum_acc_q  <= {SUM_W{1'b0}};
            ovf_acc_q  <= {OVF_W{1'b0}};
            wcnt_q     <= {WCNT_W{1'b0}};
            close_q    <= 1'b0;
            peak_o_q   <= {CNT_W{1'b0}};
            sum_o_q    <= {SUM_W{1'b0}};
            ovf_o_q    <= {OVF_W{1'b0}};
            report_q   <= 1'b0;
        end else begin
            peak_acc_q <= peak_acc_d;
            sum_acc_q  <= sum_acc_d;
            ovf_acc_q  <= ovf_acc_d;
            wcnt_q     <= wcnt_d;
            close_q    <= close_d;
            peak_o_q   <= peak_o_d;
            sum_o_q    <= sum_o_d;
            ovf_o_q    <= ovf_o_d;
            report_q   <= report_d;
        end
    end

    overflow_stretcher #(
        .STRETCH (STRETCH)
    ) u_stretch (
        .clk       (clock4x),
        .rst_n     (reset_n),
        .ovf_i     (ovf_q),
        .stretch_o (ovf_stretch_o)
    );

    assign peak_o       = peak_o_q;
    assign sum_o        = sum_o_q;
    assign ovf_cycles_o = ovf_o_q;
    assign report_o     = report_q;

endmodule

// File: doc/cluster_rate_monitor.md
Name: cluster_rate_monitor

Overview:
- Sits directly downstream of the cluster counter and consumes its per-cycle count and overflow flag on clock4x.
- Accumulates statistics over fixed windows of accepted samples: peak count, summed count, and number of overflow cycles.
- Publishes each completed window as a one-cycle report strobe.
- Provides a retriggerable stretched overflow flag for slow-control/trigger logic.

Parameters:
- CNT_W, 11, width of incoming cluster count (max 1536)
- WINDOW, 14256, accepted samples per window (3564 BX x 4 clock4x cycles); legal range 2..2^24-1
- SUM_W, 32, width of summed-count accumulator and output
- OVF_W, 16, width of overflow-cycle counter
- STRETCH, 8, clock4x cycles the stretched overflow flag is held after the last overflow; legal range 1..255

Ports:
- clock4x  in  1  sole clock
- reset_n  in  1  reset, asynchronous assert, active-low
- cnt_i  in  CNT_W  cluster count for this cycle
- overflow_i  in  1  overflow flag for this cycle
- enable_i  in  1  sample accepted when high; sample ignored when low
- resync_i  in  1  abort current window; clear accumulators
- peak_o  out  CNT_W  maximum cnt over last completed window
- sum_o  out  SUM_W  saturating sum of cnt over last completed window
- ovf_cycles_o  out  OVF_W  saturating count of overflow samples in last window
- report_o  out  1  one-cycle strobe: peak_o/sum_o/ovf_cycles_o just updated
- ovf_stretch_o  out  1  stretched overflow flag

Behaviour:
- Reset: all outputs 0; accumulators 0; window counter 0; stretch counter 0.
- Stage 0: cnt_i, overflow_i, enable_i and resync_i are registered once. Every later rule refers to these registered values.
- Stage 1, accepted sample (registered enable = 1):
  - peak_acc = max(peak_acc, cnt)
  - sum_acc = min(sum_acc + cnt, 2^SUM_W - 1)
  - ovf_acc += overflow, saturating at 2^OVF_W - 1
  - wcnt += 1
- Window close, when the accepted sample is sample number WINDOW (wcnt == WINDOW-1 before the update):
  - peak_o, sum_o and ovf_cycles_o load the values that include this final sample.
  - report_o = 1 for that one cycle.
  - peak_acc, sum_acc, ovf_acc and wcnt all return to 0.
  - The next accepted sample starts a fresh window. There are no gap cycles.
- Latency: the final sample presented on the inputs at edge N produces report_o and the updated outputs at edge N+2.
- Report outputs hold their values until the next window close. report_o is otherwise 0.
- Non-accepted samples (enable low) change nothing except the stretch logic.
- resync (registered):
  - Accumulators and wcnt clear; no report is issued.
  - resync wins over a coincident window close. The sample in that cycle is discarded.
  - Report outputs keep their previous values.
- Stretch, independent of enable and resync:
  - A registered overflow = 1 loads scnt = STRETCH. Otherwise scnt decrements, saturating at 0.
  - ovf_stretch_o is registered and equals (scnt != 0). It therefore asserts 2 edges after overflow_i and deasserts STRETCH cycles after the last overflow.
  - Retriggering during a stretch reloads scnt to STRETCH.
- Width rules:
  - Sums use full-precision (SUM_W+1)-bit internal addition followed by a clamp.
  - wcnt is ceil(log2(WINDOW)) bits wide.
  - peak uses unsigned compare.
- reset_n asserted mid-window: immediate clear of everything. The first window after deassertion starts with the first accepted sample.

Decomposition:
- Shared package (cluster_pkg) holds:
  - CNT_W default
  - constants BX_PER_ORBIT = 3564 and CLK4X_PER_BX = 4, with WINDOW derived from them
  - a saturating-add function usable by both accumulators
- One natural sub-module: overflow_stretcher, containing the reload/decrement counter and registered flag, parameterised by STRETCH.
- Window accumulation stays in the top module.

Test Plan:
- WINDOW=4, enable=1, cnt = 3, 9, 2, 5, overflow only on the 9 → report_o one cycle at edge 6 (final sample at edge 4), peak=9, sum=19, ovf_cycles=1. Outputs remain held while the next window accumulates.
- WINDOW=4, enable pattern 1,0,1,0,1,0,1 with cnt=100 on every cycle → exactly one report after the 4th accepted sample, sum=400, peak=100.
- SUM_W=8, WINDOW=4, cnt=100 on every cycle → sum_o=255 (saturated), peak=100.
- WINDOW=4, resync coincident with the 4th sample → no report_o; the next 4 samples of cnt=1 give sum=4. Previously reported values persist until then.
- STRETCH=3, single overflow_i pulse at edge 0 → ovf_stretch_o high at edges 2, 3, 4 and low at 5. A second pulse at edge 2 extends the high period through edge 6.
- reset_n asserted mid-window after two samples of cnt=7 → all outputs 0 immediately. After release, a 4-sample window of cnt=1 reports sum=4 with no residue of 14.
